// File: rtl/hamming_decoder.sv
// hamming_decoder: Hamming(7,4) check/correct, 4 data bits shifted out serially.
// Optional HAMMING_ERR_CNT_EN adds a saturating corrected-word counter.
module hamming_decoder #(
  parameter int MSB_FIRST = 0
`ifdef HAMMING_ERR_CNT_EN
  ,
  parameter int ERR_CNT_W = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           code_in,
  input  logic                 code_valid,
  output logic                 in_ready,
  output logic                 data_out,
  output logic                 out_valid,
  output logic                 done,
  output logic                 error_flag,
  output logic [2:0]           syndrome
`ifdef HAMMING_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT
  } state_t;

  state_t     state;
  logic [6:0] code_q;
  logic [3:0] d_q;
  logic [1:0] cnt;
  logic [2:0] syn;
  logic [3:0] d_fix;

  function automatic logic pick(
    input logic [3:0] d,
    input logic [1:0] i
  );
    return (MSB_FIRST != 0) ? d[2'd3 - i] : d[i];
  endfunction

  // Only data positions (3,5,6,7) are emitted, so parity flips need no fix.
  always_comb begin
    syn[0]   = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6];
    syn[1]   = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6];
    syn[2]   = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
    d_fix[0] = code_q[2] ^ (syn == 3'd3);
    d_fix[1] = code_q[4] ^ (syn == 3'd5);
    d_fix[2] = code_q[5] ^ (syn == 3'd6);
    d_fix[3] = code_q[6] ^ (syn == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      data_out   <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      error_flag <= 1'b0;
      syndrome   <= 3'd0;
      cnt        <= 2'd0;
      code_q     <= 7'd0;
      d_q        <= 4'd0;
`ifdef HAMMING_ERR_CNT_EN
      err_count  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (code_valid) begin
            code_q   <= code_in;
            in_ready <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          d_q        <= d_fix;
          syndrome   <= syn;
          error_flag <= (syn != 3'd0);
          cnt        <= 2'd0;
          out_valid  <= 1'b1;
          data_out   <= pick(d_fix, 2'd0);
          state      <= SHIFT;
`ifdef HAMMING_ERR_CNT_EN
          if (syn != 3'd0 && err_count != '1)
            err_count <= err_count + ERR_CNT_W'(1);
`endif
        end
        SHIFT: begin
          if (cnt == 2'd3) begin
            out_valid <= 1'b0;
            data_out  <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt      <= cnt + 2'd1;
            data_out <= pick(d_q, cnt + 2'd1);
            done     <= (cnt == 2'd2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
